// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// Imported by fetch_stage and pc_reg.
package pipe_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    localparam addr_t RESET_PC_DEF = 32'h0000_0000;
    localparam word_t NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_BOOT,
        FS_RUN,
        FS_HALT
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
// Contains the next-PC mux and the +4 incrementer.
module pc_reg
    import pipe_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);

    addr_t pc_q;
    addr_t pc_d;

    assign pc4_o = pc_q + 32'd4;
    assign pc_o  = pc_q;

    always_comb begin
        pc_d = pc4_o;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (hold_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Holds the BOOT/RUN/HALT FSM and the IF/ID register.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEF,
    parameter word_t NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        halted_o
);

    fetch_state_e state_q, state_d;
    word_t        instr_q, instr_d;
    addr_t        pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         pc_hold, pc_load;
    addr_t        pc, pc4;
    logic         misaligned;

    assign misaligned = (redirect_pc_i[1:0] != 2'b00);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold_i    (pc_hold),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc_i),
        .pc_o      (pc),
        .pc4_o     (pc4)
    );

    always_comb begin
        state_d = state_q;
        pc_hold = 1'b1;
        pc_load = 1'b0;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        unique case (state_q)
            FS_BOOT: state_d = FS_RUN;
            FS_RUN: begin
                // redirect > flush > stall > sequential
                if (redirect_i) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    if (misaligned) begin
                        state_d = FS_HALT;
                    end else begin
                        pc_load = 1'b1;
                    end
                end else if (flush_i) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    pc_hold = stall_i;
                end else if (!stall_i) begin
                    pc_hold = 1'b0;
                    instr_d = imem_data_i;
                    pc4_d   = pc4;
                    valid_d = 1'b1;
                end
            end
            FS_HALT: valid_d = 1'b0;
            default: state_d = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_BOOT;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr_o   = pc;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;
    assign halted_o      = (state_q == FS_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random
// stall/flush/redirect traffic against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic        halted_o;

    int   n_chk = 0;
    int   n_fail = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'd0) return 32'h0844_3000;
        if (a == 32'd4) return 32'h1802_000A;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_data_i = rom(imem_addr_o);

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o),
        .halted_o      (halted_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    // Behavioural model of the fetch rules
    int          m_st;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st    <= M_BOOT;
            m_pc    <= 32'd0;
            m_instr <= NOP;
            m_pc4   <= 32'd0;
            m_valid <= 1'b0;
        end else if (m_st == M_BOOT) begin
            m_st <= M_RUN;
        end else if (m_st == M_RUN) begin
            if (redirect_i) begin
                m_valid <= 1'b0;
                m_instr <= NOP;
                if (redirect_pc_i % 4 == 0) m_pc <= redirect_pc_i;
                else m_st <= M_HALT;
            end else if (flush_i) begin
                m_valid <= 1'b0;
                m_instr <= NOP;
                if (!stall_i) m_pc <= m_pc + 32'd4;
            end else if (!stall_i) begin
                m_instr <= rom(m_pc);
                m_pc4   <= m_pc + 32'd4;
                m_valid <= 1'b1;
                m_pc    <= m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("addr", imem_addr_o, m_pc);
            chk("instr", if_id_instr_o, m_instr);
            chk("valid", {31'b0, if_id_valid_o}, {31'b0, m_valid});
            chk("halted", {31'b0, halted_o}, {31'b0, (m_st == M_HALT)});
            if (m_valid) chk("pc4", if_id_pc4_o, m_pc4);
        end
    end

    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic s, input logic f, input logic r,
                         input logic [31:0] t);
        stall_i       = s;
        flush_i       = f;
        redirect_i    = r;
        redirect_pc_i = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, imem_addr_o, 32'd0);
        chk({tag, "_instr"}, if_id_instr_o, NOP);
        chk({tag, "_pc4"}, if_id_pc4_o, 32'd0);
        chk({tag, "_valid"}, {31'b0, if_id_valid_o}, 32'd0);
        chk({tag, "_halted"}, {31'b0, halted_o}, 32'd0);
    endtask

    initial begin
        int          halt_cnt;
        logic [31:0] r;
        logic [31:0] frozen;
        halt_cnt = 0;
        rst_n = 1'b0;
        #12;
        chk_reset_vals("rst");
        chk_en = 1'b1;
        rst_n  = 1'b1;

        next_edge();
        chk("boot_valid", {31'b0, if_id_valid_o}, 32'd0);
        chk("boot_addr", imem_addr_o, 32'd0);
        next_edge();
        chk("e2_instr", if_id_instr_o, 32'h0844_3000);
        chk("e2_pc4", if_id_pc4_o, 32'd4);
        chk("e2_valid", {31'b0, if_id_valid_o}, 32'd1);
        next_edge();
        chk("e3_instr", if_id_instr_o, 32'h1802_000A);
        chk("e3_pc4", if_id_pc4_o, 32'd8);
        chk("e3_addr", imem_addr_o, 32'd8);

        drive(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) begin
            next_edge();
            chk("stall_addr", imem_addr_o, 32'd8);
            chk("stall_instr", if_id_instr_o, 32'h1802_000A);
            chk("stall_pc4", if_id_pc4_o, 32'd8);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        next_edge();
        chk("resume_addr", imem_addr_o, 32'd12);

        drive(1'b1, 1'b0, 1'b1, 32'h0000_0018);
        next_edge();
        chk("redir_addr", imem_addr_o, 32'h18);
        chk("redir_valid", {31'b0, if_id_valid_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        next_edge();
        chk("redir_pc4", if_id_pc4_o, 32'h1C);
        chk("redir_valid2", {31'b0, if_id_valid_o}, 32'd1);

        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        next_edge();
        chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        next_edge();
        chk("wrap_addr", imem_addr_o, 32'd0);
        chk("wrap_pc4", if_id_pc4_o, 32'd0);

        for (int i = 0; i < 800; i++) begin
            r = $urandom;
            if ($urandom % 25 == 0)
                r = {r[31:2], 2'($urandom_range(1, 3))};
            else if ($urandom % 10 == 0)
                r = 32'hFFFF_FFF8;
            else
                r = {r[31:2], 2'b00};
            drive(($urandom % 100) < 30, ($urandom % 100) < 15,
                  ($urandom % 100) < 8, r);
            next_edge();
            if (m_st == M_HALT) halt_cnt++;
            if (halt_cnt > 5 || ($urandom % 200) == 0) begin
                do_reset();
                halt_cnt = 0;
            end
        end

        drive(1'b0, 1'b0, 1'b0, 32'd0);
        do_reset();
        next_edge();
        next_edge();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0016);
        next_edge();
        frozen = 32'd4;
        chk("halt_flag", {31'b0, halted_o}, 32'd1);
        chk("halt_valid", {31'b0, if_id_valid_o}, 32'd0);
        chk("halt_addr", imem_addr_o, frozen);
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            next_edge();
            chk("halt_hold", imem_addr_o, frozen);
            chk("halt_stay", {31'b0, halted_o}, 32'd1);
        end

        drive(1'b0, 1'b0, 1'b0, 32'd0);
        do_reset();
        next_edge();
        next_edge();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        next_edge();
        chk("pre_rst_valid", {31'b0, if_id_valid_o}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        next_edge();
        next_edge();
        next_edge();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word driven when IF/ID is invalid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall_i  input  1  hold PC and IF/ID contents.
REQ-006 flush_i  input  1  invalidate IF/ID at next edge.
REQ-007 redirect_i  input  1  branch/jump taken; load redirect_pc_i.
REQ-008 redirect_pc_i  input  32  byte-address target.
REQ-009 imem_addr_o  output  32  instruction ROM byte address (current PC).
REQ-010 imem_data_i  input  32  instruction ROM data, combinational from imem_addr_o.
REQ-011 if_id_instr_o  output  32  registered instruction.
REQ-012 if_id_pc4_o  output  32  registered PC+4 of that instruction.
REQ-013 if_id_valid_o  output  1  IF/ID holds a real instruction.
REQ-014 halted_o  output  1  fetch halted on misaligned redirect.

Function
REQ-015 FSM states: BOOT, RUN, HALT; reset enters BOOT.
REQ-016 BOOT lasts exactly one cycle; no instruction is captured; always transitions to RUN.
REQ-017 RUN: imem_addr_o = PC combinationally; IF/ID captures imem_data_i and PC+4 at the edge; latency address-to-if_id_instr_o is 1 cycle.
REQ-018 Per-edge priority in RUN: redirect_i > flush_i > stall_i > sequential.
REQ-019 Sequential: PC <= PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0); IF/ID loaded, valid=1.
REQ-020 stall_i alone: PC, if_id_instr_o, if_id_pc4_o, if_id_valid_o all unchanged.
REQ-021 flush_i (no redirect): PC advances unless stall_i is 1; if_id_valid_o <= 0, if_id_instr_o <= NOP_WORD; flush overrides stall for IF/ID.
REQ-022 redirect_i with redirect_pc_i[1:0]==0: PC <= redirect_pc_i regardless of stall_i; IF/ID flushed as REQ-021.
REQ-023 redirect_i with redirect_pc_i[1:0]!=0: PC unchanged, IF/ID flushed, FSM -> HALT.
REQ-024 HALT: PC frozen, if_id_valid_o=0, halted_o=1; exit only via rst_n.
REQ-025 halted_o is 1 only in HALT; redirect/flush/stall are ignored in BOOT and HALT.
REQ-026 PC[1:0] is always 2'b00 while in RUN.

Reset
REQ-027 rst_n low asynchronously forces: PC=RESET_PC, imem_addr_o=RESET_PC, if_id_instr_o=NOP_WORD, if_id_pc4_o=0, if_id_valid_o=0, halted_o=0, state=BOOT.
REQ-028 Reset asserted mid-operation, including during stall or HALT, discards all in-flight state with no partial update.
REQ-029 First fetch of RESET_PC is captured at the second rising edge after rst_n deasserts.

Structure
REQ-030 Shared package pipe_pkg holds RESET_PC default, NOP_WORD, the fetch-state enum, and the 32-bit word/address typedefs.
REQ-031 A single sub-module pc_reg holds the PC: async-reset register, next-PC mux, +4 incrementer.
REQ-032 FSM and IF/ID register reside in fetch_stage; no memory inside the block.

Verification
REQ-033 Reset release, no stall, ROM word0=32'h0844_3000, word1=32'h1802_000A -> after edge 2: instr=32'h0844_3000, pc4=4, valid=1; after edge 3: instr=32'h1802_000A, pc4=8.
REQ-034 stall_i high for 3 cycles at PC=8 -> imem_addr_o stays 8; IF/ID outputs constant; resumes at 12.
REQ-035 redirect_i with target 32'h0000_0018 while stall_i=1 -> next imem_addr_o=0x18, valid=0 for one cycle; following capture has pc4=0x1C.
REQ-036 redirect_i with target 32'h0000_0016 -> halted_o=1, valid=0, PC frozen through 10 further cycles, until rst_n pulse.
REQ-037 PC forced to 32'hFFFF_FFFC via redirect -> next PC=0, captured pc4=0.
REQ-038 rst_n pulsed low mid-stall with valid=1 -> outputs take REQ-027 values immediately, without waiting for a clk edge.
